spi_controller: RTL and testbench



---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_cmd_fifo.sv | 57 +++++
 rtl/spi_controller.sv | 193 +++++++++++++++++++
 tb/tb_spi_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write initiator.
package spi_pkg;

   localparam int unsigned SPI_FRAME_W = 16;
   localparam int unsigned SPI_ADDR_W  = 7;

   localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_LO = 7'd0;
   localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_HI = 7'd1;
   localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_LO = 7'd2;
   localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_HI = 7'd3;
   localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY  = 7'd4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_state_e;

   function automatic logic [SPI_FRAME_W-1:0] spi_frame(
      input logic                  rw,
      input logic [SPI_ADDR_W-1:0] addr,
      input logic [7:0]            data
   );
      return {rw, addr, data};
   endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Two-entry command FIFO placed ahead of the SPI FSM; only built when
// SPI_CMD_QUEUE_EN is defined.
module spi_cmd_fifo #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_q, wr_d;
   logic         rd_q, rd_d;
   logic [1:0]   cnt_q, cnt_d;

   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      wr_d     = wr_q;
      rd_d     = rd_q;
      if (push) begin
         mem_d[wr_q] = din;
         wr_d        = ~wr_q;
      end
      if (pop) begin
         rd_d = ~rd_q;
      end
      cnt_d = cnt_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dout  = mem_q[rd_q];
   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator sending 16-bit {rw, addr, data} frames, MSB first.
// Define SPI_CMD_QUEUE_EN to place a 2-entry command FIFO ahead of the FSM.
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 4,
   parameter int unsigned CS_HOLD  = 4,
   parameter int unsigned CS_IDLE  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic       nCS,
   output logic       SCLK,
   output logic       copi
);

   localparam int unsigned PH_W  = $clog2(CLK_DIV) + 1;
   localparam int unsigned CNT_W = 16;

   spi_state_e             state_q, state_d;
   logic [PH_W-1:0]        ph_q, ph_d;
   logic [4:0]             bit_q, bit_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SPI_FRAME_W-1:0] shreg_q, shreg_d;
   logic                   ncs_q, ncs_d;
   logic                   sclk_q, sclk_d;
   logic                   copi_q, copi_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                   start;
   logic [SPI_FRAME_W-1:0] start_frame;
   logic                   ph_last;
   logic                   bit_adv;

`ifdef SPI_CMD_QUEUE_EN
   logic                   fifo_full;
   logic                   fifo_empty;

   spi_cmd_fifo #(
      .W(SPI_FRAME_W)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid && !fifo_full),
      .din   (spi_frame(cmd_rw, cmd_addr, cmd_data)),
      .pop   (start),
      .dout  (start_frame),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign start     = (state_q == IDLE) && !fifo_empty;
   assign cmd_ready = !fifo_full;
`else
   logic ready_q, ready_d;

   assign start       = cmd_valid && ready_q;
   assign start_frame = spi_frame(cmd_rw, cmd_addr, cmd_data);
   assign cmd_ready   = ready_q;
`endif

   assign ph_last = (ph_q == PH_W'(CLK_DIV - 1));
   // Falling SCLK edge that moves on to the next bit (not after the last one).
   assign bit_adv = (state_q == SHIFT) && ph_last && sclk_q && (bit_q != 5'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ph_q    <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         shreg_q <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifndef SPI_CMD_QUEUE_EN
         ready_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         ncs_q   <= ncs_d;
         sclk_q  <= sclk_d;
         copi_q  <= copi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifndef SPI_CMD_QUEUE_EN
         ready_q <= ready_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
               shreg_d = start_frame;
               cnt_d   = '0;
            end
         end
         SETUP: begin
            if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
               state_d = SHIFT;
               cnt_d   = '0;
               ph_d    = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (ph_last) begin
               ph_d = '0;
               if (bit_adv) begin
                  bit_d   = bit_q + 5'd1;
                  shreg_d = {shreg_q[SPI_FRAME_W-2:0], shreg_q[SPI_FRAME_W-1]};
               end else if (sclk_q) begin
                  state_d = HOLD;
                  bit_d   = '0;
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            // The done cycle plus CS_IDLE further cycles of nCS high.
            if (cnt_q == CNT_W'(CS_IDLE)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ncs_d  = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
      sclk_d = 1'b0;
      if (state_q == SHIFT) begin
         sclk_d = ph_last ? ~sclk_q : sclk_q;
      end
      copi_d = copi_q;
      if ((state_q == IDLE) && start) begin
         copi_d = start_frame[SPI_FRAME_W-1];
      end else if (state_d == GAP) begin
         copi_d = 1'b0;
      end else if (bit_adv) begin
         copi_d = shreg_d[SPI_FRAME_W-1];
      end
      busy_d = (state_d != IDLE);
      done_d = (state_q == HOLD) && (state_d == GAP);
`ifndef SPI_CMD_QUEUE_EN
      ready_d = (state_d == IDLE);
`endif
   end

   assign busy = busy_q;
   assign done = done_q;
   assign nCS  = ncs_q;
   assign SCLK = sclk_q;
   assign copi = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench: pin-level SPI peripheral model plus a command-level
// register model, driving a default instance and a CLK_DIV=2 instance.
module tb_spi_controller;

   localparam int unsigned SETUP_C = 4;
   localparam int unsigned HOLD_C  = 4;
   localparam int unsigned IDLE_C  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid;
   logic       sel;
   logic       rw_i;
   logic [6:0] addr_i;
   logic [7:0] data_i;

   logic v1, ready1, busy1, done1, ncs1, sclk1, copi1;
   logic v2, ready2, busy2, done2, ncs2, sclk2, copi2;
   logic ready_m, busy_m, done_m, ncs_m, sclk_m, copi_m;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned acc1   = 0;

   logic [7:0] exp_regs [5];
   logic [7:0] per_regs [5];

   always #5 clk = ~clk;

   assign v1 = valid && !sel;
   assign v2 = valid && sel;

   assign ready_m = sel ? ready2 : ready1;
   assign busy_m  = sel ? busy2  : busy1;
   assign done_m  = sel ? done2  : done1;
   assign ncs_m   = sel ? ncs2   : ncs1;
   assign sclk_m  = sel ? sclk2  : sclk1;
   assign copi_m  = sel ? copi2  : copi1;

   spi_controller u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (v1),
      .cmd_ready (ready1),
      .cmd_rw    (rw_i),
      .cmd_addr  (addr_i),
      .cmd_data  (data_i),
      .busy      (busy1),
      .done      (done1),
      .nCS       (ncs1),
      .SCLK      (sclk1),
      .copi      (copi1)
   );

   spi_controller #(
      .CLK_DIV(2)
   ) u_dut_div2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (v2),
      .cmd_ready (ready2),
      .cmd_rw    (rw_i),
      .cmd_addr  (addr_i),
      .cmd_data  (data_i),
      .busy      (busy2),
      .done      (done2),
      .nCS       (ncs2),
      .SCLK      (sclk2),
      .copi      (copi2)
   );

   always @(posedge clk) begin
      if (v1 && ready1) acc1 <= acc1 + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called on a negedge; returns on a negedge with the DUT idle again.
   task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                            input bit keep, input bit abort);
      logic [15:0] exp_f;
      logic [15:0] got_f;
      logic        prev_sclk;
      int unsigned div, rises, ncs_low, ready_low, busy_cyc, dones, ncs_exp, w;
      bit          aborted;
      exp_f     = {rw, addr, data};
      got_f     = '0;
      prev_sclk = 1'b0;
      div       = sel ? 2 : 4;
      rises     = 0;
      ncs_low   = 0;
      ready_low = 0;
      busy_cyc  = 0;
      dones     = 0;
      aborted   = 1'b0;
      w         = 0;
      while (!ready_m && w < 400) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_cmd", ready_m, 1);
      rw_i   = rw;
      addr_i = addr;
      data_i = data;
      valid  = 1'b1;
      @(negedge clk);
      if (!keep) valid = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if (n > 0) @(negedge clk);
         if (ready_m) break;
         ready_low++;
         if (busy_m) busy_cyc++;
         if (!ncs_m) ncs_low++;
         if (done_m) dones++;
         if (sclk_m && !prev_sclk) begin
            rises++;
            got_f = {got_f[14:0], copi_m};
         end
         prev_sclk = sclk_m;
         if (abort && rises == 8 && sclk_m) begin
            rst_n = 1'b0;
            #1;
            check("abort_ncs", ncs_m, 1);
            check("abort_sclk", sclk_m, 0);
            check("abort_ready", ready_m, 1);
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         @(negedge clk);
         rst_n = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (done_m) dones++;
            @(negedge clk);
         end
         check("abort_no_done", dones, 0);
         check("abort_ncs_after", ncs_m, 1);
         return;
      end
      ncs_exp = SETUP_C + 32 * div + HOLD_C;
      check("frame_end_ready", ready_m, 1);
      check("frame_bits", got_f, exp_f);
      check("sclk_rises", rises, 16);
      check("ncs_low_cycles", ncs_low, ncs_exp);
      check("ready_low_cycles", ready_low, 1 + ncs_exp + IDLE_C);
      check("busy_cycles", busy_cyc, 1 + ncs_exp + IDLE_C);
      check("done_pulses", dones, 1);
      check("idle_pins", {ncs_m, sclk_m, copi_m}, 3'b100);
      if (rw && addr < 5) exp_regs[addr] = data;
      if (rises == 16 && got_f[15] && got_f[14:8] < 5) per_regs[got_f[14:8]] = got_f[7:0];
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 5; i++) check(tag, per_regs[i], exp_regs[i]);
   endtask

   initial begin
      logic [7:0]  wdata [5];
      int unsigned a0;
      wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44; wdata[4] = 8'h80;
      for (int i = 0; i < 5; i++) begin
         exp_regs[i] = '0;
         per_regs[i] = '0;
      end
      valid  = 1'b0;
      sel    = 1'b0;
      rw_i   = 1'b0;
      addr_i = '0;
      data_i = '0;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", ready1, 1);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_ncs", ncs1, 1);
      check("rst_sclk", sclk1, 0);
      check("rst_copi", copi1, 0);

      run_frame(1'b1, 7'd0, 8'hA5, 1'b0, 1'b0);
      check("reg0_a5", per_regs[0], 8'hA5);

      for (int i = 0; i < 5; i++) run_frame(1'b1, 7'(i), wdata[i], 1'b0, 1'b0);
      check_regs("regs_5writes");

      run_frame(1'b0, 7'd4, 8'h12, 1'b0, 1'b0);
      check("read_keeps_duty", per_regs[4], 8'h80);

      a0 = acc1;
      run_frame(1'b1, 7'd1, 8'($urandom), 1'b1, 1'b0);
      check("held_valid_one_accept", acc1 - a0, 1);
      run_frame(1'b1, 7'd2, 8'($urandom), 1'b0, 1'b0);
      check("held_valid_second", acc1 - a0, 2);

      run_frame(1'b1, 7'd3, 8'h5A, 1'b0, 1'b1);
      run_frame(1'b1, 7'd3, 8'h6B, 1'b0, 1'b0);
      check("after_abort_reg3", per_regs[3], 8'h6B);

      for (int i = 0; i < 6; i++) begin
         run_frame(1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b0);
      end
      check_regs("regs_random");

      sel = 1'b1;
      @(negedge clk);
      run_frame(1'b1, 7'd3, 8'hC3, 1'b0, 1'b0);
      check("div2_reg3", per_regs[3], 8'hC3);
      run_frame(1'($urandom), 7'($urandom_range(0, 4)), 8'($urandom), 1'b0, 1'b0);
      check_regs("regs_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
